// File: rtl/dff_checker.sv
// In-circuit checker for a synchronous-reset/set D flop: models the expected Q
// alongside the flop under test and counts compared cycles and mismatches.
module dff_checker #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             clr_cnt,
    input  logic             mon_d,
    input  logic             mon_rst,
    input  logic             mon_set,
    input  logic             mon_q,
    output logic             exp_q,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             model_q, model_d;
    logic             mismatch_q, mismatch_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
    logic             model_val;
    logic             miss;

    // model_q always holds the previous edge's model result, which is what
    // the flop's Q should show during the current cycle.
    always_comb begin
        model_val  = !mon_rst ? 1'b0 : (mon_set ? 1'b1 : mon_d);
        miss       = (mon_q != model_q);
        state_d    = state_q;
        model_d    = model_q;
        mismatch_d = 1'b0;
        sticky_d   = sticky_q;
        err_cnt_d  = err_cnt_q;
        chk_cnt_d  = chk_cnt_q;

        case (state_q)
            IDLE: begin
                if (chk_en) state_d = ARM;
            end
            ARM: begin
                model_d = model_val;
                state_d = chk_en ? CHECK : IDLE;
            end
            CHECK: begin
                model_d    = model_val;
                mismatch_d = miss;
                if (chk_cnt_q != CNT_MAX) chk_cnt_d = chk_cnt_q + CNT_ONE;
                if (miss) begin
                    sticky_d = 1'b1;
                    if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
                end
                if (!chk_en)
                    state_d = IDLE;
                else if (STOP_ON_ERR && miss)
                    state_d = HALT;
            end
            HALT: begin
                if (!chk_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A clear beats any increment on the same edge.
        if (clr_cnt) begin
            err_cnt_d = '0;
            chk_cnt_d = '0;
            sticky_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            model_q    <= 1'b0;
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
            err_cnt_q  <= '0;
            chk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            model_q    <= model_d;
            mismatch_q <= mismatch_d;
            sticky_q   <= sticky_d;
            err_cnt_q  <= err_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
        end
    end

    assign exp_q      = model_q;
    assign mismatch   = mismatch_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = err_cnt_q;
    assign chk_cnt    = chk_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_dff_checker.sv
// Directed bench for dff_checker: a vector table for the main flow plus
// hand-written sequences for halt, saturation/clear and async reset.
module tb_dff_checker;

    typedef struct {
        logic       en, clr, d, r, s, f;
        logic       eq, mis, stk;
        logic [7:0] ec, cc;
        logic [1:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b0, clr_cnt = 1'b0, mon_d = 1'b0, mon_rst = 1'b0, mon_set = 1'b0;
    logic fault = 1'b0;
    logic ref_q = 1'b0;
    logic mon_q;

    logic       a_eq, a_mis, a_stk;
    logic [7:0] a_ec, a_cc;
    logic [1:0] a_st;
    logic       h_eq, h_mis, h_stk;
    logic [7:0] h_ec, h_cc;
    logic [1:0] h_st;
    logic       s_eq, s_mis, s_stk;
    logic [1:0] s_ec, s_cc;
    logic [1:0] s_st;

    int checks = 0;
    int errors = 0;
    vec_t tbl[20];

    always #5 clk = ~clk;

    // Behaves like a correct flop under test; fault inverts what the checker sees.
    always @(posedge clk) ref_q <= !mon_rst ? 1'b0 : (mon_set ? 1'b1 : mon_d);
    assign mon_q = ref_q ^ fault;

    dff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr_cnt(clr_cnt), .mon_d(mon_d),
        .mon_rst(mon_rst), .mon_set(mon_set), .mon_q(mon_q), .exp_q(a_eq),
        .mismatch(a_mis), .err_sticky(a_stk), .err_cnt(a_ec), .chk_cnt(a_cc), .state(a_st));

    dff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr_cnt(clr_cnt), .mon_d(mon_d),
        .mon_rst(mon_rst), .mon_set(mon_set), .mon_q(mon_q), .exp_q(h_eq),
        .mismatch(h_mis), .err_sticky(h_stk), .err_cnt(h_ec), .chk_cnt(h_cc), .state(h_st));

    dff_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) dut_s (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr_cnt(clr_cnt), .mon_d(mon_d),
        .mon_rst(mon_rst), .mon_set(mon_set), .mon_q(mon_q), .exp_q(s_eq),
        .mismatch(s_mis), .err_sticky(s_stk), .err_cnt(s_ec), .chk_cnt(s_cc), .state(s_st));

    function automatic vec_t mk(input logic en, clr, d, r, s, f, eq, mis, stk,
                                input int ec, cc, st);
        vec_t v;
        v.en = en; v.clr = clr; v.d = d; v.r = r; v.s = s; v.f = f;
        v.eq = eq; v.mis = mis; v.stk = stk;
        v.ec = 8'(ec); v.cc = 8'(cc); v.st = 2'(st);
        return v;
    endfunction

    task automatic checkVal(input string name, input int idx, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    // Drive at the falling edge, let one rising edge consume it, return at the next falling edge.
    task automatic step(input logic en, clr, d, r, s, f);
        chk_en = en; clr_cnt = clr; mon_d = d; mon_rst = r; mon_set = s; fault = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,1,0,0, 0,0,0, 0, 0,1);
        tbl[1]  = mk(1,0,1,1,0,0, 1,0,0, 0, 0,2);
        tbl[2]  = mk(1,0,0,1,0,0, 0,0,0, 0, 1,2);
        tbl[3]  = mk(1,0,1,1,0,0, 1,0,0, 0, 2,2);
        tbl[4]  = mk(1,0,0,1,0,0, 0,0,0, 0, 3,2);
        tbl[5]  = mk(1,0,1,1,0,0, 1,0,0, 0, 4,2);
        tbl[6]  = mk(1,0,0,1,0,0, 0,0,0, 0, 5,2);
        tbl[7]  = mk(1,0,1,1,0,0, 1,0,0, 0, 6,2);
        tbl[8]  = mk(1,0,0,1,0,0, 0,0,0, 0, 7,2);
        tbl[9]  = mk(1,0,1,1,0,0, 1,0,0, 0, 8,2);
        tbl[10] = mk(1,0,1,0,1,0, 0,0,0, 0, 9,2);
        tbl[11] = mk(1,0,0,1,1,0, 1,0,0, 0,10,2);
        tbl[12] = mk(1,0,1,1,0,0, 1,0,0, 0,11,2);
        tbl[13] = mk(1,0,1,1,0,1, 1,1,1, 1,12,2);
        tbl[14] = mk(1,0,0,1,0,0, 0,0,1, 1,13,2);
        tbl[15] = mk(1,0,0,1,0,0, 0,0,1, 1,14,2);
        tbl[16] = mk(0,0,1,1,0,0, 1,0,1, 1,15,0);
        tbl[17] = mk(0,0,0,1,0,0, 1,0,1, 1,15,0);
        tbl[18] = mk(0,1,0,1,0,0, 1,0,0, 0, 0,0);
        tbl[19] = mk(0,0,0,1,0,0, 1,0,0, 0, 0,0);

        // Reset state, held across a few clock edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_state", 0, a_st, 0);
        checkVal("rst_exp_q", 0, a_eq, 0);
        checkVal("rst_mismatch", 0, a_mis, 0);
        checkVal("rst_sticky", 0, a_stk, 0);
        checkVal("rst_err_cnt", 0, a_ec, 0);
        checkVal("rst_chk_cnt", 0, a_cc, 0);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].d, tbl[i].r, tbl[i].s, tbl[i].f);
            checkVal("tbl_exp_q", i, a_eq, tbl[i].eq);
            checkVal("tbl_mismatch", i, a_mis, tbl[i].mis);
            checkVal("tbl_sticky", i, a_stk, tbl[i].stk);
            checkVal("tbl_err_cnt", i, a_ec, tbl[i].ec);
            checkVal("tbl_chk_cnt", i, a_cc, tbl[i].cc);
            checkVal("tbl_state", i, a_st, tbl[i].st);
        end

        // STOP_ON_ERR: first mismatch halts and freezes everything
        pulseReset();
        step(1,0,1,1,0,0);
        step(1,0,0,1,0,0);
        step(1,0,1,1,0,1);
        checkVal("halt_state", 0, h_st, 3);
        checkVal("halt_mismatch", 0, h_mis, 1);
        checkVal("halt_err_cnt", 0, h_ec, 1);
        checkVal("halt_chk_cnt", 0, h_cc, 1);
        checkVal("halt_exp_q", 0, h_eq, 1);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, i[0], 1, 0, i[1]);
            checkVal("halt_state", i, h_st, 3);
            checkVal("halt_mismatch", i, h_mis, 0);
            checkVal("halt_err_cnt", i, h_ec, 1);
            checkVal("halt_chk_cnt", i, h_cc, 1);
            checkVal("halt_exp_q", i, h_eq, 1);
        end
        step(0,0,0,1,0,0);
        checkVal("halt_exit_state", 0, h_st, 0);
        checkVal("halt_exit_sticky", 0, h_stk, 1);

        // CNT_W=2 saturation, then clear on an erroring edge
        pulseReset();
        step(1,0,0,1,0,0);
        step(1,0,0,1,0,0);
        for (int k = 1; k <= 6; k++) begin
            step(1,0,0,1,0,1);
            checkVal("sat_err_cnt", k, s_ec, (k > 3) ? 3 : k);
            checkVal("sat_chk_cnt", k, s_cc, (k > 3) ? 3 : k);
            checkVal("sat_mismatch", k, s_mis, 1);
        end
        step(1,1,0,1,0,1);
        checkVal("clr_err_cnt", 0, s_ec, 0);
        checkVal("clr_chk_cnt", 0, s_cc, 0);
        checkVal("clr_sticky", 0, s_stk, 0);
        checkVal("clr_state", 0, s_st, 2);
        step(1,0,0,1,0,0);
        checkVal("post_clr_chk_cnt", 0, s_cc, 1);
        checkVal("post_clr_err_cnt", 0, s_ec, 0);

        // Asynchronous reset between edges while in CHECK
        step(1,0,1,1,0,0);
        checkVal("pre_arst_exp_q", 0, a_eq, 1);
        checkVal("pre_arst_chk_cnt", 0, a_cc, 2);
        #2 rst = 1'b0;
        #1;
        checkVal("arst_state", 0, a_st, 0);
        checkVal("arst_exp_q", 0, a_eq, 0);
        checkVal("arst_chk_cnt", 0, a_cc, 0);
        checkVal("arst_err_cnt", 0, a_ec, 0);
        checkVal("arst_sticky", 0, a_stk, 0);
        checkVal("arst_mismatch", 0, a_mis, 0);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkVal("rearm_state", 1, a_st, 1);
        checkVal("rearm_chk_cnt", 1, a_cc, 0);
        step(1,0,1,1,0,0);
        checkVal("rearm_state", 2, a_st, 2);
        checkVal("rearm_chk_cnt", 2, a_cc, 0);
        step(1,0,1,1,0,0);
        checkVal("rearm_chk_cnt", 3, a_cc, 1);
        checkVal("rearm_mismatch", 3, a_mis, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
